// File: rtl/vp_ctrl_pkg.sv
// Shared types and constants for the binarisation-stage frame controller.
package vp_ctrl_pkg;

  typedef enum logic [1:0] {
    S_WAIT,
    S_MEASURE,
    S_LOCKED
  } state_t;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_BIN    = 2'd1;
  localparam logic [1:0] MODE_INV    = 2'd2;

  localparam logic [7:0] VP_DEF_THR  = 8'd128;
  localparam logic [1:0] VP_DEF_MODE = MODE_BIN;

  // The reserved encoding 3 behaves as bypass.
  function automatic logic [1:0] map_mode(input logic [1:0] m);
    case (m)
      MODE_BIN: return MODE_BIN;
      MODE_INV: return MODE_INV;
      default:  return MODE_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/vp_timing_cnt.sv
// Raster edge detection plus pixel/line/frame counters; strobes the measured
// width of each line on the de falling edge.
module vp_timing_cnt #(
  parameter int PIX_W   = 12,
  parameter int LINE_W  = 12,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_in,
  input  logic               v_sync_in,
  output logic               vs_rise,
  output logic               de_fall,
  output logic               frame_start,
  output logic [PIX_W-1:0]   pix_cnt,
  output logic [LINE_W-1:0]  line_cnt,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [PIX_W-1:0]   line_w
);

  logic vs_q;
  logic de_q;

  assign vs_rise = v_sync_in & ~vs_q;
  assign de_fall = de_q & ~de_in;
  assign line_w  = pix_cnt + 1'b1;

  // pix_cnt trails de by one cycle, so on de_fall it holds the index of the
  // last active pixel and the line length is that index plus one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      frame_start <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      frame_cnt   <= '0;
    end else begin
      vs_q        <= v_sync_in;
      de_q        <= de_in;
      frame_start <= vs_rise;

      if (de_fall)
        pix_cnt <= '0;
      else if (de_in && de_q && pix_cnt != '1)
        pix_cnt <= pix_cnt + 1'b1;

      if (vs_rise)
        line_cnt <= '0;
      else if (de_fall && line_cnt != '1)
        line_cnt <= line_cnt + 1'b1;

      if (vs_rise)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vp_frame_ctrl.sv
// Frame-synchronous controller: geometry lock FSM and threshold/mode updates
// that take effect only at frame start.
module vp_frame_ctrl
  import vp_ctrl_pkg::*;
#(
  parameter int         PIX_W    = 12,
  parameter int         LINE_W   = 12,
  parameter int         FRAME_W  = 16,
  parameter logic [7:0] DEF_THR  = VP_DEF_THR,
  parameter logic [1:0] DEF_MODE = VP_DEF_MODE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_in,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic               cfg_req,
  input  logic [7:0]         cfg_thr,
  input  logic [1:0]         cfg_mode,
  output logic               cfg_ack,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic [7:0]         thr_out,
  output logic [1:0]         mode_out,
  output logic               bypass,
  output logic               frame_start,
  output logic [PIX_W-1:0]   pix_cnt,
  output logic [LINE_W-1:0]  line_cnt,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [PIX_W-1:0]   width,
  output logic [LINE_W-1:0]  height,
  output logic               locked,
  output logic               geom_err
);

  localparam logic [1:0] RST_MODE = map_mode(DEF_MODE);

  logic             vs_rise;
  logic             de_fall;
  logic [PIX_W-1:0] line_w;
  state_t           state;
  logic             have_w;
  logic [7:0]       pend_thr;
  logic [1:0]       pend_mode;

  // Line boundaries come from de alone; hsync carries no extra information.
  logic unused_hsync;
  assign unused_hsync = h_sync_in;

  vp_timing_cnt #(
    .PIX_W   (PIX_W),
    .LINE_W  (LINE_W),
    .FRAME_W (FRAME_W)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .de_in       (de_in),
    .v_sync_in   (v_sync_in),
    .vs_rise     (vs_rise),
    .de_fall     (de_fall),
    .frame_start (frame_start),
    .pix_cnt     (pix_cnt),
    .line_cnt    (line_cnt),
    .frame_cnt   (frame_cnt),
    .line_w      (line_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT;
      width    <= '0;
      height   <= '0;
      locked   <= 1'b0;
      geom_err <= 1'b0;
      have_w   <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (vs_rise) begin
            state    <= S_MEASURE;
            geom_err <= 1'b0;
            have_w   <= 1'b0;
          end
        end
        S_MEASURE: begin
          if (vs_rise) begin
            height   <= line_cnt;
            geom_err <= 1'b0;
            have_w   <= 1'b0;
            if (!geom_err && line_cnt != '0) begin
              state  <= S_LOCKED;
              locked <= 1'b1;
            end
          end else if (de_fall) begin
            if (!have_w) begin
              width  <= line_w;
              have_w <= 1'b1;
            end else if (line_w != width) begin
              geom_err <= 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (vs_rise) begin
            geom_err <= 1'b0;
            have_w   <= 1'b0;
            if (line_cnt != height) begin
              state  <= S_MEASURE;
              locked <= 1'b0;
            end
          end else if (de_fall && line_w != width) begin
            // Keep comparing the rest of this frame against the old width.
            geom_err <= 1'b1;
            have_w   <= 1'b1;
            state    <= S_MEASURE;
            locked   <= 1'b0;
          end
        end
        default: begin
          state  <= S_WAIT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // A capture blocks the apply path that cycle, so a request arriving with
  // vsync is held for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_out   <= DEF_THR;
      mode_out  <= RST_MODE;
      bypass    <= (RST_MODE == MODE_BYPASS);
      pend_thr  <= '0;
      pend_mode <= '0;
      cfg_ack   <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      cfg_ack  <= 1'b0;
      cfg_done <= 1'b0;
      if (cfg_req && !cfg_busy && !cfg_ack) begin
        pend_thr  <= cfg_thr;
        pend_mode <= cfg_mode;
        cfg_ack   <= 1'b1;
        cfg_busy  <= 1'b1;
      end else if (vs_rise && cfg_busy) begin
        thr_out  <= pend_thr;
        mode_out <= map_mode(pend_mode);
        bypass   <= (map_mode(pend_mode) == MODE_BYPASS);
        cfg_busy <= 1'b0;
        cfg_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/vp_frame_ctrl.md
Name: vp_frame_ctrl

Overview:
- Frame-synchronous controller for the binarisation stage, between hdmi_in and the video-processing datapath.
- Tracks raster position and locks onto frame geometry.
- Accepts threshold/mode updates from a requester via req/ack handshake; applies them only at frame start, so no frame is processed with mixed settings.
- Drives the datapath's threshold, bypass and mode controls plus timing status.

Parameters:
- PIX_W, 12, pixel-counter width (max 4095 pixels per line)
- LINE_W, 12, line-counter width
- FRAME_W, 16, frame-counter width
- DEF_THR, 8'd128, threshold after reset
- DEF_MODE, 2'd1, mode after reset (0 bypass, 1 binarise, 2 inverted binarise, 3 reserved → treated as 0)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- de_in  in  1  data enable from hdmi_in
- h_sync_in  in  1  hsync, active-high
- v_sync_in  in  1  vsync, active-high
- cfg_req  in  1  requester holds high until cfg_ack
- cfg_thr  in  8  requested threshold
- cfg_mode  in  2  requested mode
- cfg_ack  out  1  one-cycle pulse, request captured
- cfg_busy  out  1  update pending, not yet applied
- cfg_done  out  1  one-cycle pulse, pending update applied
- thr_out  out  8  active threshold to datapath
- mode_out  out  2  active mode (3 mapped to 0)
- bypass  out  1  mode_out==0
- frame_start  out  1  one-cycle pulse on vsync rising edge
- pix_cnt  out  PIX_W  index of current active pixel in line
- line_cnt  out  LINE_W  active lines completed in current frame
- frame_cnt  out  FRAME_W  frames seen since reset, wraps
- width  out  PIX_W  measured line width
- height  out  LINE_W  measured frame height
- locked  out  1  geometry stable
- geom_err  out  1  sticky until next frame_start; line width differs from width

Behaviour:
- Reset values: thr_out=DEF_THR, mode_out=DEF_MODE, bypass=(DEF_MODE==0); all counters, width, height 0; all flags and pulses 0; state S_WAIT; pending registers cleared.
- All outputs registered.
- Edge detect: vs_q, de_q registers. vs_rise = v_sync_in & ~vs_q; de_fall = de_q & ~de_in.
- pix_cnt: increments each de_in cycle, saturating at all-ones. Cleared the cycle after de_fall.
- line_cnt: increments on de_fall (saturating); cleared on vs_rise.
- frame_cnt: increments on vs_rise, wraps to 0.
- frame_start: high the cycle after vs_rise.
- Line-width capture on de_fall: line_w = pix_cnt + 1 (the de_fall cycle's pixel is not counted).
- FSM states S_WAIT, S_MEASURE, S_LOCKED.
- S_WAIT:
  - ignores de_in for geometry;
  - on vs_rise → S_MEASURE.
- S_MEASURE:
  - first de_fall of frame sets width = line_w;
  - later line_w != width sets geom_err;
  - on vs_rise: height = line_cnt; if geom_err==0 and line_cnt!=0 → S_LOCKED (locked=1), else stay.
- S_LOCKED:
  - any line_w != width sets geom_err and → S_MEASURE (locked=0) at that de_fall;
  - vs_rise with line_cnt != height → S_MEASURE, locked=0.
- geom_err clears on every vs_rise.
- Config handshake:
  - cfg_req && !cfg_busy && !cfg_ack: capture cfg_thr/cfg_mode into pending; cfg_ack=1 next cycle; cfg_busy=1.
  - cfg_req while cfg_busy: no capture; requester keeps holding.
- Apply:
  - on vs_rise with cfg_busy=1: thr_out/mode_out/bypass load pending; cfg_busy=0; cfg_done=1 next cycle.
  - capture and vs_rise in the same cycle: capture wins; apply waits for the next vs_rise.
  - apply happens in every state, including the S_WAIT→S_MEASURE transition.
- Latency: vs_rise to updated thr_out/mode_out is 1 cycle.
- Async reset mid-frame: immediate return to reset values; any pending request is discarded, with no ack/done.

Decomposition:
- Package vp_ctrl_pkg: state enum (S_WAIT, S_MEASURE, S_LOCKED), mode encodings (MODE_BYPASS, MODE_BIN, MODE_INV), DEF_THR/DEF_MODE constants.
- Sub-module vp_timing_cnt: edge detection plus pix/line/frame counters and the line_w strobe.
- Top holds the FSM, geometry registers and config handshake.

Test Plan:
- Reset, then frames of 8 px × 3 lines:
  - first vs_rise: S_MEASURE, frame_cnt=1;
  - second vs_rise: width=8, height=3, locked=1;
  - thr_out=128, mode_out=1 throughout.
- In S_LOCKED mid-frame, cfg_req with thr=0x40, mode=0:
  - cfg_ack after 1 cycle, cfg_busy=1, thr_out still 0x80;
  - next vs_rise: thr_out=0x40, bypass=1, cfg_done pulse, cfg_busy=0.
- Second cfg_req (thr=0x10) while busy: no ack until after apply; then acked, applied at the following vs_rise.
- Inject one 7-pixel line in a locked 8×3 stream: geom_err=1 and locked=0 at that de_fall; clean frames re-lock after two vs_rise.
- cfg_req asserted in the vs_rise cycle: ack next cycle; thr_out unchanged until the following vs_rise.
- rst_n low mid-line with a request pending: outputs instantly DEF_THR/DEF_MODE, counters 0, no cfg_done; state S_WAIT.
